clk_en_gen: RTL and testbench

CLK_EN_GEN -- requirements
Module: clk_en_gen

---
 rtl/clk_en_gen_if.sv | 23 ++
 rtl/clk_en_gen.sv | 103 ++++++++++
 tb/tb_clk_en_gen.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/clk_en_gen_if.sv
// Divisor-write bus for clk_en_gen: the host writes a divisor, and the block replies with ack or err.
interface clk_en_gen_if #(
    parameter int CHANNELS = 2,
    parameter int DIV_W    = 16
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic             div_wr;
    logic [SEL_W-1:0] div_sel;
    logic [DIV_W-1:0] div_data;
    logic             div_ack;
    logic             div_err;

    modport master (
        output div_wr, div_sel, div_data,
        input  div_ack, div_err
    );

    modport slave (
        input  div_wr, div_sel, div_data,
        output div_ack, div_err
    );
endinterface

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator with glitch-free divisor updates.
// tick and clk_out are registered data signals in the clk_48M domain.
module clk_en_gen #(
    parameter int CHANNELS    = 2,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 48000
) (
    input  logic                clk_48M,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                resync,
    clk_en_gen_if.slave         div_if,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] clk_out
);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    logic [CHANNELS-1:0][DIV_W-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0][DIV_W-1:0] div_q, div_d;
    logic [CHANNELS-1:0][DIV_W-1:0] shadow_q, shadow_d;
    logic [CHANNELS-1:0]            run_q, run_d;
    logic [CHANNELS-1:0]            tick_q, tick_d;
    logic [CHANNELS-1:0]            clk_out_q, clk_out_d;
    logic                           ack_q, ack_d;
    logic                           err_q, err_d;
    logic                           wr_ok;
    logic                           wrap;

    always_comb begin
        wr_ok = div_if.div_wr && (div_if.div_data != '0) &&
                (32'(div_if.div_sel) < 32'(CHANNELS));
        ack_d = wr_ok;
        err_d = div_if.div_wr && !wr_ok;
        wrap  = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            shadow_d[i]  = shadow_q[i];
            cnt_d[i]     = cnt_q[i];
            div_d[i]     = div_q[i];
            run_d[i]     = run_q[i];
            tick_d[i]    = 1'b0;
            clk_out_d[i] = clk_out_q[i];
            if (wr_ok && (32'(div_if.div_sel) == i))
                shadow_d[i] = div_if.div_data;
            wrap = run_q[i] && (cnt_q[i] == div_q[i] - ONE);
            // Every reload reads shadow_d, so a write landing on the same
            // edge (wrap, resync, idle) takes effect immediately.
            if (resync) begin
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
                div_d[i]     = shadow_d[i];
                run_d[i]     = en[i];
            end else if (!en[i]) begin
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
                div_d[i]     = shadow_d[i];
                run_d[i]     = 1'b0;
            end else if (!run_q[i]) begin
                // First enabled edge holds cnt at 0 so the first tick lands N edges later.
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
                div_d[i]     = shadow_d[i];
                run_d[i]     = 1'b1;
            end else if (wrap) begin
                cnt_d[i]     = '0;
                tick_d[i]    = 1'b1;
                clk_out_d[i] = ~clk_out_q[i];
                div_d[i]     = shadow_d[i];
            end else begin
                cnt_d[i]     = cnt_q[i] + ONE;
            end
        end
    end

    always_ff @(posedge clk_48M) begin
        if (rst) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i]    <= '0;
                div_q[i]    <= DIV_RST;
                shadow_q[i] <= DIV_RST;
            end
            run_q     <= '0;
            tick_q    <= '0;
            clk_out_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            run_q     <= run_d;
            tick_q    <= tick_d;
            clk_out_q <= clk_out_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign tick           = tick_q;
    assign clk_out        = clk_out_q;
    assign div_if.div_ack = ack_q;
    assign div_if.div_err = err_q;
endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen: expected tick edges and write responses are queued and checked every cycle.
module tb_clk_en_gen;
    localparam int CH = 3;

    logic          clk_48M = 1'b0;
    logic          rst;
    logic [CH-1:0] en;
    logic          resync;
    logic [CH-1:0] tick;
    logic [CH-1:0] clk_out;

    clk_en_gen_if #(.CHANNELS(CH), .DIV_W(16)) div_if ();

    clk_en_gen #(.CHANNELS(CH), .DIV_W(16), .DEFAULT_DIV(4)) dut (
        .clk_48M (clk_48M),
        .rst     (rst),
        .en      (en),
        .resync  (resync),
        .div_if  (div_if),
        .tick    (tick),
        .clk_out (clk_out)
    );

    always #5 clk_48M = ~clk_48M;

    typedef struct {
        int   c;
        logic a;
        logic e;
    } resp_t;

    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;
    int    tq[CH][$];
    resp_t rq[$];

    always @(posedge clk_48M) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk_48M);
    endtask

    task automatic wr_div(input int sel, input int data, input bit ok);
        rq.push_back('{c: cyc + 1, a: ok, e: !ok});
        div_if.div_wr   = 1'b1;
        div_if.div_sel  = 2'(sel);
        div_if.div_data = 16'(data);
        @(negedge clk_48M);
        div_if.div_wr   = 1'b0;
    endtask

    // Per-cycle monitor: tick and ack/err must be high exactly on queued cycles.
    always @(negedge clk_48M) begin
        logic exp_t;
        logic exp_a;
        logic exp_e;
        for (int i = 0; i < CH; i++) begin
            exp_t = 1'b0;
            if (tq[i].size() > 0 && tq[i][0] == cyc) begin
                exp_t = 1'b1;
                void'(tq[i].pop_front());
            end
            chk($sformatf("tick%0d", i), 32'(tick[i]), 32'(exp_t));
        end
        exp_a = 1'b0;
        exp_e = 1'b0;
        if (rq.size() > 0 && rq[0].c == cyc) begin
            exp_a = rq[0].a;
            exp_e = rq[0].e;
            void'(rq.pop_front());
        end
        chk("div_ack", 32'(div_if.div_ack), 32'(exp_a));
        chk("div_err", 32'(div_if.div_err), 32'(exp_e));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0, t, p, q, s;
        rst             = 1'b1;
        en              = '0;
        resync          = 1'b0;
        div_if.div_wr   = 1'b0;
        div_if.div_sel  = '0;
        div_if.div_data = '0;
        @(negedge clk_48M);
        // Outputs must stay at reset values whatever the other inputs do.
        en              = '1;
        resync          = 1'b1;
        div_if.div_wr   = 1'b1;
        div_if.div_data = 16'd9;
        repeat (2) begin
            @(negedge clk_48M);
            chk("rst_hold_clk_out", 32'(clk_out), 32'd0);
        end
        rst           = 1'b0;
        en            = '0;
        resync        = 1'b0;
        div_if.div_wr = 1'b0;
        @(negedge clk_48M);
        chk("reset_clk_out", 32'(clk_out), 32'd0);
        chk("reset_tick", 32'(tick), 32'd0);

        // Channel 0 at default N=4.
        k0 = cyc;
        en = 3'b001;
        tq[0].push_back(k0 + 5);
        tq[0].push_back(k0 + 9);
        tq[0].push_back(k0 + 13);
        wait_cyc(k0 + 5);
        chk("clk_out_rise", 32'(clk_out), 32'd1);
        wait_cyc(k0 + 8);
        chk("clk_out_high", 32'(clk_out), 32'd1);
        wait_cyc(k0 + 9);
        chk("clk_out_fall", 32'(clk_out), 32'd0);

        // Write 6 at cnt=1: current period stays 4, then 6.
        t = k0 + 13;
        wait_cyc(t + 1);
        tq[0].push_back(t + 4);
        tq[0].push_back(t + 10);
        tq[0].push_back(t + 16);
        wr_div(0, 6, 1'b1);
        wait_cyc(t + 9);
        chk("clk_out_n6_low", 32'(clk_out), 32'd0);
        wait_cyc(t + 10);
        chk("clk_out_n6_high", 32'(clk_out), 32'd1);

        // Rejected writes leave spacing unchanged.
        p = t + 16;
        wait_cyc(p + 1);
        tq[0].push_back(p + 6);
        tq[0].push_back(p + 12);
        wr_div(0, 0, 1'b0);
        wr_div(3, 5, 1'b0);

        // Back-to-back writes: last value (3) wins at the next wrap.
        wait_cyc(p + 13);
        tq[0].push_back(p + 18);
        tq[0].push_back(p + 21);
        tq[0].push_back(p + 24);
        wr_div(0, 5, 1'b1);
        wr_div(0, 3, 1'b1);

        // Write landing on the wrap edge bypasses straight to the active divisor.
        wait_cyc(p + 23);
        tq[0].push_back(p + 29);
        tq[0].push_back(p + 34);
        wr_div(0, 5, 1'b1);

        wait_cyc(p + 34);
        en = 3'b000;
        @(negedge clk_48M);
        chk("disable_clk_out", 32'(clk_out), 32'd0);
        chk("disable_tick", 32'(tick), 32'd0);
        wr_div(0, 4, 1'b1);
        wr_div(1, 6, 1'b1);

        // Two channels N=4 / N=6, then resync with a concurrent write of 5 to ch0.
        q  = cyc;
        en = 3'b011;
        tq[0].push_back(q + 5);
        tq[0].push_back(q + 13);
        tq[0].push_back(q + 18);
        tq[0].push_back(q + 23);
        tq[1].push_back(q + 7);
        tq[1].push_back(q + 14);
        for (int c = q + 20; c <= q + 25; c++) tq[1].push_back(c);
        wait_cyc(q + 7);
        chk("pre_resync_clk_out", 32'(clk_out), 32'd3);
        rq.push_back('{c: cyc + 1, a: 1'b1, e: 1'b0});
        resync          = 1'b1;
        div_if.div_wr   = 1'b1;
        div_if.div_sel  = 2'd0;
        div_if.div_data = 16'd5;
        @(negedge clk_48M);
        resync        = 1'b0;
        div_if.div_wr = 1'b0;
        chk("resync_clk_out", 32'(clk_out), 32'd0);

        // N=1 on channel 1: continuous tick, clk_out toggles each cycle.
        wait_cyc(q + 15);
        wr_div(1, 1, 1'b1);
        wait_cyc(q + 21);
        chk("n1_clk_out_a", 32'(clk_out[1]), 32'd1);
        wait_cyc(q + 22);
        chk("n1_clk_out_b", 32'(clk_out[1]), 32'd0);
        wait_cyc(q + 25);
        chk("n1_clk_out_c", 32'(clk_out), 32'd3);

        // Reset mid-run with a write pending: no response, outputs cleared.
        rst             = 1'b1;
        div_if.div_wr   = 1'b1;
        div_if.div_sel  = 2'd0;
        div_if.div_data = 16'd7;
        @(negedge clk_48M);
        div_if.div_wr = 1'b0;
        chk("midrun_rst_clk_out", 32'(clk_out), 32'd0);
        chk("midrun_rst_tick", 32'(tick), 32'd0);
        @(negedge clk_48M);
        chk("rst_hold2_clk_out", 32'(clk_out), 32'd0);
        rst = 1'b0;

        // Divisors back at default 4 on both channels.
        s = cyc;
        tq[0].push_back(s + 5);
        tq[0].push_back(s + 9);
        tq[1].push_back(s + 5);
        tq[1].push_back(s + 9);
        wait_cyc(s + 10);

        for (int i = 0; i < CH; i++)
            chk($sformatf("tick_queue%0d_drained", i), 32'(tq[i].size()), 32'd0);
        chk("resp_queue_drained", 32'(rq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
